// File: rtl/input_debouncer_if.sv
// Raw board inputs and conditioned outputs of the input debouncer.
// master: the board / stimulus side that drives raw levels and observes results.
// slave:  the debouncer itself.
interface input_debouncer_if;
  logic [6:0] key_raw;
  logic [1:0] octave_raw;
  logic       confirm_raw;
  logic [6:0] key_out;
  logic [1:0] octave_out;
  logic       confirm_out;
  logic [6:0] key_press;
  logic [1:0] octave_press;
  logic       confirm_press;
  logic [2:0] key_index;
  logic       key_valid;

  modport master (
    output key_raw, octave_raw, confirm_raw,
    input  key_out, octave_out, confirm_out,
    input  key_press, octave_press, confirm_press,
    input  key_index, key_valid
  );

  modport slave (
    input  key_raw, octave_raw, confirm_raw,
    output key_out, octave_out, confirm_out,
    output key_press, octave_press, confirm_press,
    output key_index, key_valid
  );
endinterface

// File: rtl/input_debouncer.sv
// Input conditioning for the piano: 2-FF synchronisers, a shared 1 ms tick,
// per-input debounce counters, press pulses and a most-recent-held-key index.
// Optional feature macro: OCTAVE_AUTOREPEAT_EN adds auto-repeat pulses on held
// octave keys; without it each debounced octave press gives a single pulse.
// Bit order of the internal 10-bit vectors: [6:0] keys, [8:7] octave, [9] confirm.
module input_debouncer #(
  parameter int CLK_HZ          = 100000000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 200
) (
  input  logic             clk,
  input  logic             reset,
  input_debouncer_if.slave bus
);
  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW       = $clog2(DEBOUNCE_MS + 1);
  localparam int NIN      = 10;
  localparam int NKEY     = 7;

  if (TICK_DIV < 1 || DEBOUNCE_MS < 1 || REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_param_check
    $error("input_debouncer: parameter out of range");
  end

  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [NIN-1:0] raw_all, sync1, sync2;
  logic [NIN-1:0] stable, toggle, rise;
  logic [CW-1:0]  cnt [NIN];
  logic [NIN-1:0] press_d, press_q;
  logic [1:0]     oct_repeat;
  logic [2:0]     key_index_q, next_index, lowest_press, lowest_held;
  logic           key_valid_q, index_held;

  assign raw_all = {bus.confirm_raw, bus.octave_raw, bus.key_raw};
  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));

  // Free-running millisecond divider; tick is high in the cycle it wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Two-stage synchroniser for every raw input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  // An input flips its stable level on the tick that completes the window.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < NIN; i++)
      toggle[i] = (sync2[i] != stable[i]) && tick && (cnt[i] == CW'(DEBOUNCE_MS - 1));
  end

  assign rise = toggle & ~stable;

  // Debounce counters: any cycle agreeing with the stable level restarts the window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (toggle[i]) begin
            stable[i] <= ~stable[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef OCTAVE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt [2];
  logic [1:0]    rep_phase;
  logic [1:0]    rep_fire;

  // A repeat fires on the tick that ends the first delay, then each rate period.
  always_comb begin
    rep_fire = '0;
    for (int j = 0; j < 2; j++)
      rep_fire[j] = stable[7+j] && !toggle[7+j] && tick &&
                    (rep_cnt[j] == (rep_phase[j] ? RW'(REPEAT_RATE_MS - 1) : RW'(REPEAT_DELAY_MS - 1)));
  end

  // Per-octave-key hold timers, cleared whenever the key is not solidly held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_phase <= '0;
      for (int j = 0; j < 2; j++) rep_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!stable[7+j] || toggle[7+j]) begin
          rep_cnt[j]   <= '0;
          rep_phase[j] <= 1'b0;
        end else if (tick) begin
          if (rep_fire[j]) begin
            rep_cnt[j]   <= '0;
            rep_phase[j] <= 1'b1;
          end else begin
            rep_cnt[j] <= rep_cnt[j] + 1'b1;
          end
        end
      end
    end
  end

  assign oct_repeat = rep_fire;
`else
  assign oct_repeat = 2'b00;
`endif

  assign press_d = {rise[9], rise[8:7] | oct_repeat, rise[6:0]};

  // Press pulses are registered so they line up with the first cycle the level reads 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) press_q <= '0;
    else        press_q <= press_d;
  end

  // Pick the new key index from this cycle's pulses and held levels.
  always_comb begin
    lowest_press = '0;
    lowest_held  = '0;
    index_held   = 1'b0;
    for (int i = NKEY - 1; i >= 0; i--) begin
      if (press_q[i]) lowest_press = 3'(i);
      if (stable[i])  lowest_held  = 3'(i);
      if (key_index_q == 3'(i)) index_held = stable[i];
    end
    next_index = key_index_q;
    if (|press_q[NKEY-1:0])      next_index = lowest_press;
    else if (!(|stable[NKEY-1:0])) next_index = '0;
    else if (!index_held)        next_index = lowest_held;
  end

  // Most-recent-held-key tracking, one cycle behind the key levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_index_q <= '0;
      key_valid_q <= 1'b0;
    end else begin
      key_index_q <= next_index;
      key_valid_q <= |stable[NKEY-1:0];
    end
  end

  assign bus.key_out       = stable[6:0];
  assign bus.octave_out    = stable[8:7];
  assign bus.confirm_out   = stable[9];
  assign bus.key_press     = press_q[6:0];
  assign bus.octave_press  = press_q[8:7];
  assign bus.confirm_press = press_q[9];
  assign bus.key_index     = key_index_q;
  assign bus.key_valid     = key_valid_q;
endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (tick every 10 cycles, 4 ms window).
// Stimulus pushes the expected output snapshot of every output change together
// with the cycle window it must appear in; a monitor compares on each change.
module tb_input_debouncer;
  localparam int CLK_HZ          = 10000;
  localparam int DEBOUNCE_MS     = 4;
  localparam int REPEAT_DELAY_MS = 10;
  localparam int REPEAT_RATE_MS  = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  input_debouncer_if bus();

  input_debouncer #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
    .REPEAT_RATE_MS(REPEAT_RATE_MS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] snap;
    int          lo;
    int          hi;
    int          off;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc       = 0;
  int          checks    = 0;
  int          errors    = 0;
  int          last_evt  = 0;
  logic [23:0] prev_snap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] mk(input logic [6:0] ko, input logic [6:0] kp,
                                     input logic [1:0] oo, input logic [1:0] op,
                                     input logic co, input logic cp,
                                     input logic [2:0] idx, input logic v);
    return {ko, kp, oo, op, co, cp, idx, v};
  endfunction

  function automatic logic [23:0] cur_snap();
    return {bus.key_out, bus.key_press, bus.octave_out, bus.octave_press,
            bus.confirm_out, bus.confirm_press, bus.key_index, bus.key_valid};
  endfunction

  function automatic void expect_abs(input logic [23:0] s, input int t);
    exp_t e;
    e.snap = s; e.lo = t + 32; e.hi = t + 42; e.off = 0;
    sb_q.push_back(e);
  endfunction

  function automatic void expect_rel(input logic [23:0] s, input int off);
    exp_t e;
    e.snap = s; e.lo = 0; e.hi = 0; e.off = off;
    sb_q.push_back(e);
  endfunction

  task automatic applyStimulus(input logic [6:0] keys, input logic [1:0] oct,
                               input logic conf, output int t);
    @(negedge clk);
    bus.key_raw     = keys;
    bus.octave_raw  = oct;
    bus.confirm_raw = conf;
    t = cyc;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [23:0] want);
    logic [23:0] got;
    got = cur_snap();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, got, want);
    end
  endtask

  // Monitor: every change of the output snapshot pops and checks one expectation.
  initial begin : monitor
    logic [23:0] snap;
    exp_t        item;
    int          lo, hi;
    lo = 0; hi = 0;
    forever begin
      @(negedge clk);
      snap = cur_snap();
      if (sb_q.size() > 0) begin
        if (sb_q[0].off > 0) begin
          lo = last_evt + sb_q[0].off;
          hi = lo;
        end else begin
          lo = sb_q[0].lo;
          hi = sb_q[0].hi;
        end
      end
      if (snap !== prev_snap) begin
        checks++;
        prev_snap = snap;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_event at cycle %0d: got %h, wanted no change", cyc, snap);
        end else begin
          item = sb_q.pop_front();
          last_evt = cyc;
          if (snap !== item.snap || cyc < lo || cyc > hi)
            begin
              errors++;
              $display("[TB] FAIL event: got %h at cycle %0d, wanted %h in cycles %0d..%0d",
                       snap, cyc, item.snap, lo, hi);
            end
        end
      end else if (sb_q.size() > 0 && cyc > hi) begin
        checks++;
        errors++;
        item = sb_q.pop_front();
        $display("[TB] FAIL missing_event: got no change by cycle %0d, wanted %h", cyc, item.snap);
        last_evt = cyc;
      end
    end
  end

  initial begin : stimulus
    int t;
    int hold;
    bus.key_raw     = 7'h7F;
    bus.octave_raw  = 2'b00;
    bus.confirm_raw = 1'b0;
    #1 reset = 1'b0;

    // Reset with all keys held, then release: full window, pulses, index 0.
    wait_cycles(5);
    checkOutput("reset_state", mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0));
    reset = 1'b1;
    t = cyc;
    expect_abs(mk(7'h7F, 7'h7F, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), t);
    expect_rel(mk(7'h7F, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1), 1);
    wait_cycles(60);

    applyStimulus(7'h00, 2'b00, 1'b0, t);
    expect_abs(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1), t);
    expect_rel(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), 1);
    wait_cycles(60);

    // Clean press and release of key 3.
    applyStimulus(7'h08, 2'b00, 1'b0, t);
    expect_abs(mk(7'h08, 7'h08, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), t);
    expect_rel(mk(7'h08, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd3, 1'b1), 1);
    wait_cycles(60);
    applyStimulus(7'h00, 2'b00, 1'b0, t);
    expect_abs(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd3, 1'b1), t);
    expect_rel(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), 1);
    wait_cycles(60);

    // Bouncing key 5 never stays high long enough: no output change at all.
    applyStimulus(7'h20, 2'b00, 1'b0, t);
    wait_cycles(24);
    applyStimulus(7'h00, 2'b00, 1'b0, t);
    wait_cycles(4);
    applyStimulus(7'h20, 2'b00, 1'b0, t);
    wait_cycles(24);
    applyStimulus(7'h00, 2'b00, 1'b0, t);
    wait_cycles(60);

    // Priority: 2 and 6 together, then 4, release 4, release 2, release 6.
    applyStimulus(7'h44, 2'b00, 1'b0, t);
    expect_abs(mk(7'h44, 7'h44, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), t);
    expect_rel(mk(7'h44, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd2, 1'b1), 1);
    wait_cycles(60);
    applyStimulus(7'h54, 2'b00, 1'b0, t);
    expect_abs(mk(7'h54, 7'h10, 2'b00, 2'b00, 1'b0, 1'b0, 3'd2, 1'b1), t);
    expect_rel(mk(7'h54, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd4, 1'b1), 1);
    wait_cycles(60);
    applyStimulus(7'h44, 2'b00, 1'b0, t);
    expect_abs(mk(7'h44, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd4, 1'b1), t);
    expect_rel(mk(7'h44, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd2, 1'b1), 1);
    wait_cycles(60);
    applyStimulus(7'h40, 2'b00, 1'b0, t);
    expect_abs(mk(7'h40, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd2, 1'b1), t);
    expect_rel(mk(7'h40, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd6, 1'b1), 1);
    wait_cycles(60);
    applyStimulus(7'h00, 2'b00, 1'b0, t);
    expect_abs(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd6, 1'b1), t);
    expect_rel(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), 1);
    wait_cycles(60);

    // Confirm held for 60 cycles: one pulse, level follows.
    applyStimulus(7'h00, 2'b00, 1'b1, t);
    expect_abs(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b1, 1'b1, 3'd0, 1'b0), t);
    expect_rel(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b1, 1'b0, 3'd0, 1'b0), 1);
    wait_cycles(59);
    applyStimulus(7'h00, 2'b00, 1'b0, t);
    expect_abs(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), t);
    wait_cycles(60);

    // Octave down held briefly: single pulse in every build.
    applyStimulus(7'h00, 2'b01, 1'b0, t);
    expect_abs(mk(7'h00, 7'h00, 2'b01, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0), t);
    expect_rel(mk(7'h00, 7'h00, 2'b01, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), 1);
    wait_cycles(59);
    applyStimulus(7'h00, 2'b00, 1'b0, t);
    expect_abs(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), t);
    wait_cycles(60);

    // Octave up held: one pulse, or initial plus repeats at +100 and +150.
    applyStimulus(7'h00, 2'b10, 1'b0, t);
    expect_abs(mk(7'h00, 7'h00, 2'b10, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0), t);
    expect_rel(mk(7'h00, 7'h00, 2'b10, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), 1);
`ifdef OCTAVE_AUTOREPEAT_EN
    expect_rel(mk(7'h00, 7'h00, 2'b10, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0), 99);
    expect_rel(mk(7'h00, 7'h00, 2'b10, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), 1);
    expect_rel(mk(7'h00, 7'h00, 2'b10, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0), 49);
    expect_rel(mk(7'h00, 7'h00, 2'b10, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), 1);
    hold = 175;
`else
    hold = 300;
`endif
    wait_cycles(hold - 1);
    applyStimulus(7'h00, 2'b00, 1'b0, t);
    expect_abs(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), t);
    wait_cycles(60);

    // Reset in the middle of a debounce window: a fresh full window follows.
    applyStimulus(7'h02, 2'b00, 1'b0, t);
    wait_cycles(20);
    reset = 1'b0;
    wait_cycles(3);
    checkOutput("reset_mid_debounce", mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0));
    reset = 1'b1;
    t = cyc;
    expect_abs(mk(7'h02, 7'h02, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), t);
    expect_rel(mk(7'h02, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd1, 1'b1), 1);
    wait_cycles(60);
    applyStimulus(7'h00, 2'b00, 1'b0, t);
    expect_abs(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd1, 1'b1), t);
    expect_rel(mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0), 1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 300 && sb_q.size() > 0; i++) @(negedge clk);
    while (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got no event, wanted %h", sb_q[0].snap);
      sb_q.delete(0);
    end
    wait_cycles(2);
    checkOutput("final_idle", mk(7'h00, 7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Front-end conditioning stage directly upstream of the piano top level. Takes raw board inputs (7 note keys, 2 octave keys, confirm button), synchronises and debounces them, and produces clean levels that drive the piano's key_in, octave_keys and confirm_button.
- Also produces single-cycle press pulses and a "most recent held key" index for adjustment/record logic.

Parameters:
- CLK_HZ, 100000000, system clock frequency; CLK_HZ/1000 must be >= 1.
- DEBOUNCE_MS, 20, ms an input must stay changed before the stable level follows (>= 1).
- REPEAT_DELAY_MS, 500, used only with the optional feature: hold time before the first auto-repeat.
- REPEAT_RATE_MS, 200, used only with the optional feature: auto-repeat period.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_raw  in  7  raw note keys, active-high, asynchronous to clk
- octave_raw  in  2  raw octave keys, active-high; [0]=down, [1]=up
- confirm_raw  in  1  raw confirm button, active-high
- key_out  out  7  debounced note key levels
- octave_out  out  2  debounced octave levels
- confirm_out  out  1  debounced confirm level
- key_press  out  7  one-cycle pulse per key on debounced 0->1
- octave_press  out  2  one-cycle pulse on debounced 0->1 (plus repeats if the optional feature is enabled)
- confirm_press  out  1  one-cycle pulse on debounced 0->1
- key_index  out  3  index 0..6 of the most recently pressed held key
- key_valid  out  1  1 when any key_out bit is 1

Behaviour:
- Reset (reset=0, async): synchronisers, stable levels, counters, tick divider and all outputs go to 0; key_index=0, key_valid=0. No pulses are issued on reset release.
- Synchroniser: 2-FF per input (10 inputs total). The debouncer sees only the 2nd stage.
- Tick: one shared divider. Free-running counter 0..CLK_HZ/1000-1; `tick` is a 1-cycle strobe when it wraps (every 1 ms).
- Per-input debounce (identical for all 10 inputs): stable level s, counter c of width clog2(DEBOUNCE_MS+1).
  - Sync == s in any cycle -> c cleared that cycle. A glitch shorter than the window is fully discarded.
  - Sync != s and tick -> c increments.
  - Sync != s, tick and c == DEBOUNCE_MS-1 -> s toggles on that edge and c is cleared.
  - Latency from raw edge to s change: 2 cycles + DEBOUNCE_MS-1 to DEBOUNCE_MS ticks.
- Outputs:
  - key_out, octave_out and confirm_out equal the s registers.
  - Each *_press output is registered and is high exactly in the first cycle its s reads 1. A 1->0 change gives no pulse.
- key_index / key_valid (registered, updated in the cycle after key_out changes):
  - Any key press pulse -> key_index = index of the pressed key. If several press in the same cycle, the lowest index wins.
  - The key named by key_index releases while others remain held -> key_index = lowest held index.
  - No key held -> key_valid=0, key_index=0.
  - A release of a key other than key_index leaves key_index unchanged.
- Reset asserted mid-debounce: the count is lost. After release a still-pressed input needs a full window again and then produces a pulse.

Optional Feature:
- Macro: OCTAVE_AUTOREPEAT_EN.
- Defined:
  - While an octave_out bit stays 1, a per-key ms counter runs.
  - An extra octave_press pulse fires REPEAT_DELAY_MS after the initial pulse, then every REPEAT_RATE_MS.
  - The counter clears on release or reset; both octave keys repeat independently.
- Undefined: exactly one octave_press pulse per debounced press. The repeat counters and both repeat parameters are unused and synthesise away.

Test Plan:
- Bench setting for all scenarios: CLK_HZ=10000 (tick every 10 cycles), DEBOUNCE_MS=4.
- Reset: reset low for 5 cycles with key_raw=7'h7F held -> all outputs 0 during reset. After release, key_out=7'h7F within 2+40 cycles; key_press=7'h7F for one cycle; key_index=0, key_valid=1.
- Clean press: key_raw[3] 0->1 held -> key_out[3] rises 32..42 cycles later; key_press[3] pulses once; key_index=3. Release -> key_out[3] falls after the same window; no pulse; key_valid=0.
- Bounce: key_raw[5] toggled high for 25 cycles, low for 5, high for 25, then low -> key_out[5] stays 0, no pulses.
- Priority: press keys 2 and 6 in the same cycle -> key_index=2. Press key 4 later -> key_index=4. Release 4 -> key_index=2. Release 2 -> key_index=6.
- Confirm/octave: confirm_raw pulsed high for 60 cycles -> exactly one confirm_press. With OCTAVE_AUTOREPEAT_EN, REPEAT_DELAY_MS=10 and REPEAT_RATE_MS=5, hold octave_raw[1] for 300 cycles -> pulses at debounce+0, +100 and +150 cycles onward every 50 cycles. Without the macro -> a single pulse.
